// File: rtl/sobel_core.sv
// Streaming 3x3 Sobel magnitude over a raster gray stream with two internal line buffers.
// Result registered one cycle after the qualifying accept; no backpressure, input gaps freeze all state.
module sobel_core #(
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   in_valid_i,
  input  logic [PIXEL_WIDTH-1:0] in_px_gray_i,
  output logic                   out_valid_o,
  output logic [PIXEL_WIDTH-1:0] out_px_sobel_o,
  output logic                   frame_done_o
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SW = PIXEL_WIDTH + 3;  // signed gradient, |G| <= 4*max pixel
  localparam int MW = SW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic                   r_out_valid;
  logic [PIXEL_WIDTH-1:0] r_out_px;
  logic                   r_frame_done;

  logic [PIXEL_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] r_win [3][3];

  logic                   w_accept;
  logic                   w_col_last;
  logic                   w_row_last;
  logic                   w_win_ok;
  logic [PIXEL_WIDTH-1:0] w_nw [3][3];
  logic signed [SW-1:0]   w_gx;
  logic signed [SW-1:0]   w_gy;
  logic [SW-1:0]          w_ax;
  logic [SW-1:0]          w_ay;
  logic [MW-1:0]          w_mag;
  logic [PIXEL_WIDTH-1:0] w_sat;

  function automatic logic signed [SW-1:0] ext(input logic [PIXEL_WIDTH-1:0] x);
    return $signed({3'b000, x});
  endfunction

  assign w_accept   = (r_state == S_RUN) && start_i && in_valid_i;
  assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_win_ok   = (r_row >= RW'(2)) && (r_col >= CW'(2));

  // Window as it will look after this accept: old columns 1..2 slide left, taps form the new right column.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_nw[i][0] = r_win[i][1];
      w_nw[i][1] = r_win[i][2];
    end
    w_nw[0][2] = r_lb1[IMG_WIDTH-1];
    w_nw[1][2] = r_lb0[IMG_WIDTH-1];
    w_nw[2][2] = in_px_gray_i;
  end

  assign w_gx = (ext(w_nw[0][2]) + (ext(w_nw[1][2]) <<< 1) + ext(w_nw[2][2]))
              - (ext(w_nw[0][0]) + (ext(w_nw[1][0]) <<< 1) + ext(w_nw[2][0]));
  assign w_gy = (ext(w_nw[2][0]) + (ext(w_nw[2][1]) <<< 1) + ext(w_nw[2][2]))
              - (ext(w_nw[0][0]) + (ext(w_nw[0][1]) <<< 1) + ext(w_nw[0][2]));
  assign w_ax  = w_gx[SW-1] ? SW'(-w_gx) : SW'(w_gx);
  assign w_ay  = w_gy[SW-1] ? SW'(-w_gy) : SW'(w_gy);
  assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_sat = (|w_mag[MW-1:PIXEL_WIDTH]) ? {PIXEL_WIDTH{1'b1}} : w_mag[PIXEL_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_out_px     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid  <= 1'b0;
          r_out_px     <= '0;
          r_frame_done <= 1'b0;
          if (start_i) r_state <= S_RUN;
        end
        default: begin
          if (!start_i) begin
            // Abandon any partial frame; next run restarts at (0,0).
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_out_px     <= '0;
            r_frame_done <= 1'b0;
          end else begin
            r_out_valid  <= w_accept && w_win_ok;
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept && w_win_ok) r_out_px <= w_sat;
            if (w_accept) begin
              if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb0[0] <= in_px_gray_i;
      r_lb1[0] <= r_lb0[IMG_WIDTH-1];
      for (int k = 1; k < IMG_WIDTH; k++) begin
        r_lb0[k] <= r_lb0[k-1];
        r_lb1[k] <= r_lb1[k-1];
      end
      r_win <= w_nw;
    end
  end

  assign out_valid_o    = r_out_valid;
  assign out_px_sobel_o = r_out_px;
  assign frame_done_o   = r_frame_done;

endmodule
